// File: rtl/amstrad_mem_arbiter.sv
// Shares one SDRAM-controller port between video fetch, CPU and loader with fixed priority
// and CPU anti-starvation. Grant to mem_req is one cycle; the completion pulse follows mem_ack by one cycle.
module amstrad_mem_arbiter #(
  parameter logic [22:0] VRAM_BASE  = 23'h000000,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  output logic        vid_overrun,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        ld_wr,
  input  logic [22:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] G_VID = 2'd0;
  localparam logic [1:0] G_LD  = 2'd1;
  localparam logic [1:0] G_CPU = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]  state;
  logic [1:0]  grant;
  logic        vid_pend;
  logic [14:0] vid_addr_q;
  logic        cpu_pend;
  logic        cpu_lvl_q;
  logic        cpu_we_q;
  logic [22:0] cpu_addr_q;
  logic [7:0]  cpu_wdata_q;
  logic        ld_pend;
  logic [22:0] ld_addr_q;
  logic [7:0]  ld_data_q;
  logic [3:0]  starve_cnt;

  logic        cpu_lvl;
  logic        cpu_edge;
  logic        cpu_force;
  logic        any_pend;
  logic        cpu_free;
  logic [1:0]  nxt_grant;
  logic [22:0] vid_mem_addr;

  assign cpu_lvl      = cpu_rd | cpu_wr;
  assign cpu_edge     = cpu_lvl & ~cpu_lvl_q;
  assign cpu_force    = cpu_pend && (starve_cnt == STARVE_LIM);
  assign any_pend     = vid_pend | ld_pend | cpu_pend;
  // The CPU slot can take a new edge in the same cycle its previous access retires.
  assign cpu_free     = !cpu_pend || (state == S_DONE && grant == G_CPU);
  assign vid_mem_addr = VRAM_BASE + {7'd0, vid_addr_q, 1'b0};

  assign mem_req = (state == S_ISSUE);
  assign ld_busy = ld_pend;

  always_comb begin
    nxt_grant = G_CPU;
    if (cpu_force)     nxt_grant = G_CPU;
    else if (vid_pend) nxt_grant = G_VID;
    else if (ld_pend)  nxt_grant = G_LD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= G_VID;
      vid_pend    <= 1'b0;
      vid_addr_q  <= '0;
      vid_overrun <= 1'b0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
      cpu_pend    <= 1'b0;
      cpu_lvl_q   <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      ld_pend     <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      starve_cnt  <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      cpu_lvl_q <= cpu_lvl;
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (any_pend) begin
            grant <= nxt_grant;
            state <= S_ISSUE;
            case (nxt_grant)
              G_VID: begin
                mem_addr  <= vid_mem_addr;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
                // Video address is consumed here so a pulse during service queues the next fetch.
                vid_pend  <= 1'b0;
              end
              G_LD: begin
                mem_addr  <= ld_addr_q;
                mem_we    <= 1'b1;
                mem_wdata <= ld_data_q;
              end
              default: begin
                mem_addr  <= cpu_addr_q;
                mem_we    <= cpu_we_q;
                mem_wdata <= cpu_wdata_q;
              end
            endcase
            if (nxt_grant == G_CPU)
              starve_cnt <= '0;
            else if (cpu_pend && starve_cnt < STARVE_LIM)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            state <= S_DONE;
            if (grant == G_VID) begin
              vid_data  <= mem_rdata;
              vid_valid <= 1'b1;
            end
            if (grant == G_CPU) begin
              cpu_ack <= 1'b1;
              if (!cpu_we_q)
                cpu_rdata <= cpu_addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (grant == G_LD)  ld_pend  <= 1'b0;
          if (grant == G_CPU) cpu_pend <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // Captures come last so a new request wins over a same-cycle clear.
      if (vid_req) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vid_addr;
        if (vid_pend) vid_overrun <= 1'b1;
      end
      if (cpu_edge && cpu_free) begin
        cpu_pend    <= 1'b1;
        cpu_addr_q  <= cpu_addr;
        cpu_wdata_q <= cpu_wdata;
        cpu_we_q    <= cpu_wr;
      end
      if (ld_wr && !ld_pend) begin
        ld_pend   <= 1'b1;
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
      end
    end
  end

endmodule

// File: doc/amstrad_mem_arbiter.md
Name: amstrad_mem_arbiter

Overview:
- Shares one external memory port (SDRAM-controller side, 23-bit byte address, 16-bit read, 8-bit write) between three requesters: the video fetch path, the CPU memory cycle and the ROM/disk loader.
- Sits between the motherboard (vram_addr/vram_din, mem_addr/mem_rd/mem_wr) and the SDRAM controller.
- Arbitrates by fixed priority with CPU anti-starvation, sequences each access through a request/acknowledge FSM, and returns data to the granted requester.

Parameters:
- VRAM_BASE, 23'h000000, byte base address of the 64 KB video bank.
- STARVE_MAX, 4, consecutive lost arbitrations after which a pending CPU access wins (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vid_req  in  1  one-cycle pulse: fetch one video word
- vid_addr  in  15  video word address
- vid_data  out  16  fetched word, held until the next vid_valid
- vid_valid  out  1  one-cycle pulse: vid_data updated
- vid_overrun  out  1  sticky: a vid_req arrived while a video fetch was pending
- cpu_rd  in  1  level: CPU memory read (mem_rd)
- cpu_wr  in  1  level: CPU memory write (mem_wr)
- cpu_addr  in  23  CPU byte address (MMU output)
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read byte, held until the next cpu_ack
- cpu_ack  out  1  one-cycle pulse: CPU access complete
- ld_wr  in  1  one-cycle pulse: loader byte write
- ld_addr  in  23  loader byte address
- ld_data  in  8  loader byte
- ld_busy  out  1  loader request pending or in service
- mem_req  out  1  request to controller, held until mem_ack
- mem_we  out  1  1 = write, valid while mem_req is high
- mem_addr  out  23  byte address, stable while mem_req is high
- mem_wdata  out  8  write byte
- mem_rdata  in  16  read word, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset: FSM goes to IDLE. All pending flags, the starve counter and vid_overrun clear. mem_req, mem_we, vid_valid, cpu_ack and ld_busy are 0. mem_addr, mem_wdata, vid_data and cpu_rdata are 0.
- Request capture, every cycle:
  - vid_req sets vid_pend and latches vid_addr. If vid_pend was already set, the new address replaces the old one and vid_overrun is set.
  - A rising edge of (cpu_rd | cpu_wr) sets cpu_pend and latches address, data and direction. If cpu_wr=1 the access is a write, even when cpu_rd is also high.
  - A held cpu_rd/cpu_wr level produces exactly one access.
  - ld_wr while ld_busy=1 is dropped.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE: if any request is pending, grant and register mem_addr, mem_we and mem_wdata, then go to ISSUE.
  - ISSUE: mem_req=1 and address/data are held. On mem_ack, capture mem_rdata and go to DONE.
  - DONE: pulse the granted requester's completion output for one cycle, clear its pending flag, go to IDLE.
  - A pending flag cannot be re-set by the same request during service; a new video pulse in ISSUE/DONE sets vid_pend again for the next grant.
- Priority in IDLE: video > loader > CPU.
  - starve_cnt increments each time CPU is pending and loses. It saturates at STARVE_MAX and clears on a CPU grant.
  - When starve_cnt == STARVE_MAX, CPU wins over both other requesters.
- Address rules:
  - Video: mem_addr = VRAM_BASE + {vid_addr, 1'b0}, mem_we=0.
  - CPU/loader: mem_addr = latched address.
  - CPU read: cpu_rdata = cpu_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0].
- Latency: a request pending in IDLE at cycle N gives mem_req=1 at N+1. mem_ack at cycle M gives the completion pulse at M+1. Minimum round trip is 3 cycles from capture.
- Boundaries:
  - mem_ack outside ISSUE is ignored.
  - vid_req, CPU edge and ld_wr arriving in the same cycle are all captured.
  - Reset while in ISSUE drops mem_req at the next edge; a late mem_ack is ignored.
  - Address arithmetic wraps modulo 2^23.

Test Plan:
- Video only: VRAM_BASE=23'h040000, vid_req with vid_addr=15'h1234 -> mem_addr=23'h042468, mem_we=0. mem_ack with mem_rdata=16'hBEEF -> vid_data=16'hBEEF and a one-cycle vid_valid one cycle after the ack.
- CPU byte select: cpu_rd at cpu_addr=23'h000101, controller returns 16'hA55A -> cpu_rdata=8'hA5 with a single cpu_ack while cpu_rd is held 10 cycles. cpu_wr at 23'h000100 with data 8'h3C -> mem_we=1, mem_wdata=8'h3C.
- Simultaneous requests: vid_req, ld_wr and cpu_wr in one cycle -> grant order video, loader, CPU, with three separate mem_req/mem_ack transactions.
- Starvation: STARVE_MAX=4, vid_req every grant while cpu_rd is pending -> CPU granted on the 5th arbitration, ahead of a pending video request.
- Overrun and drop: two vid_req pulses before the first grant -> one fetch at the second address and vid_overrun=1. ld_wr while ld_busy=1 -> dropped, only one loader write.
- Reset in ISSUE: assert reset while mem_req=1 -> mem_req=0 after the edge, no ack pulses, and a subsequent mem_ack is ignored.
